// File: rtl/ct_ciu_ebiuif_crcd_ctrl.sv
// Snoop-response scheduler: round-robin CR arbitration from snb0/snb1/ctcq onto
// the registered EBIU CR channel, and in-order sequencing of 4-beat CD bursts.
module ct_ciu_ebiuif_crcd_ctrl #(
  parameter int CD_DEPTH = 4,
  parameter int CD_BEATS = 4
) (
  input  logic         forever_cpuclk,
  input  logic         cpurst,
  input  logic         snb0_ebiuif_crvalid,
  input  logic [4:0]   snb0_ebiuif_crresp,
  output logic         ebiuif_snb0_cr_grant,
  input  logic         snb0_ebiuif_cdvalid,
  input  logic [127:0] snb0_ebiuif_cddata,
  output logic         ebiuif_snb0_cd_grant,
  input  logic         snb1_ebiuif_crvalid,
  input  logic [4:0]   snb1_ebiuif_crresp,
  output logic         ebiuif_snb1_cr_grant,
  input  logic         snb1_ebiuif_cdvalid,
  input  logic [127:0] snb1_ebiuif_cddata,
  output logic         ebiuif_snb1_cd_grant,
  input  logic         ctcq_ebiuif_crvalid,
  input  logic [4:0]   ctcq_ebiuif_crresp,
  output logic         ebiuif_ctcq_cr_grant,
  output logic         ebiuif_ebiu_crvalid,
  output logic [4:0]   ebiuif_ebiu_crresp,
  input  logic         ebiu_ebiuif_cr_grant,
  output logic         ebiuif_ebiu_cdvalid,
  output logic [127:0] ebiuif_ebiu_cddata,
  output logic         ebiuif_ebiu_cdlast,
  input  logic         ebiu_ebiuif_cd_grant,
  output logic         ebiuif_cr_sel_full,
  output logic         ebiuif_crcd_idle
);

  localparam int PW = (CD_DEPTH > 1) ? $clog2(CD_DEPTH) : 1;
  localparam int CW = $clog2(CD_DEPTH + 1);
  localparam int BW = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
  localparam logic [PW-1:0] PTR_MAX   = PW'(CD_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CD_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(CD_BEATS - 1);

  typedef enum logic [1:0] {
    SRC_SNB0 = 2'd0,
    SRC_SNB1 = 2'd1,
    SRC_CTCQ = 2'd2
  } src_e;

  logic                crvalid_q;
  logic [4:0]          crresp_q;
  src_e                last_grant;
  logic [CD_DEPTH-1:0] fifo_id;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  logic [BW-1:0]       beat_cnt;

  logic       fifo_full, fifo_empty;
  logic [2:0] elig;
  logic       cr_load, cr_take;
  src_e       sel_src;
  logic [4:0] sel_resp;
  logic       push, pop;
  logic       head_id, src_cdvalid, cd_accept, beat_last;

  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign fifo_empty = (fifo_cnt == '0);

  // A full order FIFO holds back data-carrying snoop responses only.
  assign elig[0] = snb0_ebiuif_crvalid & (~snb0_ebiuif_crresp[0] | ~fifo_full);
  assign elig[1] = snb1_ebiuif_crvalid & (~snb1_ebiuif_crresp[0] | ~fifo_full);
  assign elig[2] = ctcq_ebiuif_crvalid;

  assign cr_load = ~crvalid_q | ebiu_ebiuif_cr_grant;
  assign cr_take = cr_load & (|elig) & ~cpurst;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    sel_src = SRC_SNB0;
    unique case (last_grant)
      SRC_SNB0: sel_src = elig[1] ? SRC_SNB1 : (elig[2] ? SRC_CTCQ : SRC_SNB0);
      SRC_SNB1: sel_src = elig[2] ? SRC_CTCQ : (elig[0] ? SRC_SNB0 : SRC_SNB1);
      default:  sel_src = elig[0] ? SRC_SNB0 : (elig[1] ? SRC_SNB1 : SRC_CTCQ);
    endcase
  end

  always_comb begin
    sel_resp = snb0_ebiuif_crresp;
    unique case (sel_src)
      SRC_SNB1: sel_resp = snb1_ebiuif_crresp;
      SRC_CTCQ: sel_resp = ctcq_ebiuif_crresp;
      default:  sel_resp = snb0_ebiuif_crresp;
    endcase
  end

  assign ebiuif_snb0_cr_grant = cr_take & (sel_src == SRC_SNB0);
  assign ebiuif_snb1_cr_grant = cr_take & (sel_src == SRC_SNB1);
  assign ebiuif_ctcq_cr_grant = cr_take & (sel_src == SRC_CTCQ);

  assign push = cr_take & (sel_src != SRC_CTCQ) & sel_resp[0];

  // CD channel: only the source at the head of the order FIFO is served.
  assign head_id     = fifo_id[rd_ptr];
  assign src_cdvalid = head_id ? snb1_ebiuif_cdvalid : snb0_ebiuif_cdvalid;
  assign ebiuif_ebiu_cdvalid = ~fifo_empty & src_cdvalid & ~cpurst;
  assign ebiuif_ebiu_cddata  = ebiuif_ebiu_cdvalid
                             ? (head_id ? snb1_ebiuif_cddata : snb0_ebiuif_cddata)
                             : '0;
  assign beat_last  = (beat_cnt == BEAT_LAST);
  assign cd_accept  = ebiuif_ebiu_cdvalid & ebiu_ebiuif_cd_grant;
  assign pop        = cd_accept & beat_last;
  assign ebiuif_ebiu_cdlast   = ebiuif_ebiu_cdvalid & beat_last;
  assign ebiuif_snb0_cd_grant = cd_accept & ~head_id;
  assign ebiuif_snb1_cd_grant = cd_accept & head_id;

  assign ebiuif_ebiu_crvalid = crvalid_q;
  assign ebiuif_ebiu_crresp  = crresp_q;
  assign ebiuif_cr_sel_full  = fifo_full;
  assign ebiuif_crcd_idle    = ~crvalid_q & fifo_empty & ~snb0_ebiuif_crvalid
                             & ~snb1_ebiuif_crvalid & ~ctcq_ebiuif_crvalid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      crvalid_q  <= 1'b0;
      crresp_q   <= '0;
      last_grant <= SRC_CTCQ;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      beat_cnt   <= '0;
    end else begin
      if (cr_load) begin
        crvalid_q <= |elig;
        if (|elig) crresp_q <= sel_resp;
      end
      if (cr_take) last_grant <= sel_src;
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (cd_accept) beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
    end
  end

  // NOTE: the id storage is not reset; entries are only read between a push
  // and its pop, and the count/pointers carry the reset state.
  always_ff @(posedge forever_cpuclk) begin
    if (push) fifo_id[wr_ptr] <= (sel_src == SRC_SNB1);
  end

endmodule

// File: tb/tb_ct_ciu_ebiuif_crcd_ctrl.sv
// Directed self-checking bench for ct_ciu_ebiuif_crcd_ctrl: CR round-robin,
// CD ordering, full back-pressure, CR stall, CD grant gaps and mid-burst reset.
module tb_ct_ciu_ebiuif_crcd_ctrl;

  logic         clk = 1'b0;
  logic         cpurst;
  logic         snb0_crvalid, snb1_crvalid, ctcq_crvalid;
  logic [4:0]   snb0_crresp, snb1_crresp, ctcq_crresp;
  logic         snb0_cr_gnt, snb1_cr_gnt, ctcq_cr_gnt;
  logic         snb0_cdvalid, snb1_cdvalid;
  logic [127:0] snb0_cddata, snb1_cddata;
  logic         snb0_cd_gnt, snb1_cd_gnt;
  logic         crvalid, cdvalid, cdlast, sel_full, idle;
  logic [4:0]   crresp;
  logic [127:0] cddata;
  logic         cr_grant, cd_grant;
  logic [2:0]   cr_gnt;
  logic [1:0]   cd_gnt;

  int n_checks = 0;
  int n_fail   = 0;
  int acc;

  always #5 clk = ~clk;

  assign cr_gnt = {ctcq_cr_gnt, snb1_cr_gnt, snb0_cr_gnt};
  assign cd_gnt = {snb1_cd_gnt, snb0_cd_gnt};

  ct_ciu_ebiuif_crcd_ctrl dut (
    .forever_cpuclk       (clk),
    .cpurst               (cpurst),
    .snb0_ebiuif_crvalid  (snb0_crvalid),
    .snb0_ebiuif_crresp   (snb0_crresp),
    .ebiuif_snb0_cr_grant (snb0_cr_gnt),
    .snb0_ebiuif_cdvalid  (snb0_cdvalid),
    .snb0_ebiuif_cddata   (snb0_cddata),
    .ebiuif_snb0_cd_grant (snb0_cd_gnt),
    .snb1_ebiuif_crvalid  (snb1_crvalid),
    .snb1_ebiuif_crresp   (snb1_crresp),
    .ebiuif_snb1_cr_grant (snb1_cr_gnt),
    .snb1_ebiuif_cdvalid  (snb1_cdvalid),
    .snb1_ebiuif_cddata   (snb1_cddata),
    .ebiuif_snb1_cd_grant (snb1_cd_gnt),
    .ctcq_ebiuif_crvalid  (ctcq_crvalid),
    .ctcq_ebiuif_crresp   (ctcq_crresp),
    .ebiuif_ctcq_cr_grant (ctcq_cr_gnt),
    .ebiuif_ebiu_crvalid  (crvalid),
    .ebiuif_ebiu_crresp   (crresp),
    .ebiu_ebiuif_cr_grant (cr_grant),
    .ebiuif_ebiu_cdvalid  (cdvalid),
    .ebiuif_ebiu_cddata   (cddata),
    .ebiuif_ebiu_cdlast   (cdlast),
    .ebiu_ebiuif_cd_grant (cd_grant),
    .ebiuif_cr_sel_full   (sel_full),
    .ebiuif_crcd_idle     (idle)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] t1_gnt  [3] = '{3'b001, 3'b010, 3'b100};
  logic [4:0] t1_resp [3] = '{5'h02, 5'h04, 5'h06};

  initial begin
    cpurst = 1'b1;
    snb0_crvalid = 1'b0; snb1_crvalid = 1'b0; ctcq_crvalid = 1'b0;
    snb0_crresp = '0; snb1_crresp = '0; ctcq_crresp = '0;
    snb0_cdvalid = 1'b0; snb1_cdvalid = 1'b0;
    snb0_cddata = '0; snb1_cddata = '0;
    cr_grant = 1'b0; cd_grant = 1'b0;
    tick(); tick();
    cpurst = 1'b0; #1;
    check("rst_crvalid", 128'(crvalid), 128'(1'b0));
    check("rst_crresp", 128'(crresp), 128'(5'h00));
    check("rst_cdvalid", 128'(cdvalid), 128'(1'b0));
    check("rst_cddata", cddata, 128'h0);
    check("rst_cdlast", 128'(cdlast), 128'(1'b0));
    check("rst_full", 128'(sel_full), 128'(1'b0));
    check("rst_idle", 128'(idle), 128'(1'b1));

    // 1: three requesters always valid, round-robin from snb0
    snb0_crvalid = 1'b1; snb0_crresp = 5'h02;
    snb1_crvalid = 1'b1; snb1_crresp = 5'h04;
    ctcq_crvalid = 1'b1; ctcq_crresp = 5'h06;
    cr_grant = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      check("t1_gnt", 128'(cr_gnt), 128'(t1_gnt[i % 3]));
      check("t1_crvalid", 128'(crvalid), 128'(i > 0));
      if (i > 0) check("t1_crresp", 128'(crresp), 128'(t1_resp[(i - 1) % 3]));
      tick(); #1;
    end
    snb0_crvalid = 1'b0; snb1_crvalid = 1'b0; ctcq_crvalid = 1'b0;
    tick(); #1;
    check("t1_drain_crvalid", 128'(crvalid), 128'(1'b0));
    check("t1_idle", 128'(idle), 128'(1'b1));

    // 2: snb0 then snb1 data CRs; CD served in that order
    snb0_crvalid = 1'b1; snb0_crresp = 5'h01; snb1_crresp = 5'h01; #1;
    check("t2_gnt_snb0", 128'(cr_gnt), 128'(3'b001));
    tick();
    snb0_crvalid = 1'b0; snb1_crvalid = 1'b1; #1;
    check("t2_gnt_snb1", 128'(cr_gnt), 128'(3'b010));
    check("t2_crresp", 128'(crresp), 128'(5'h01));
    tick();
    snb1_crvalid = 1'b0;
    snb1_cdvalid = 1'b1; snb1_cddata = 128'hB0; cd_grant = 1'b1; #1;
    check("t2_idle_busy", 128'(idle), 128'(1'b0));
    check("t2_nonhead_cdvalid", 128'(cdvalid), 128'(1'b0));
    check("t2_nonhead_gnt", 128'(cd_gnt), 128'(2'b00));
    check("t2_nonhead_data", cddata, 128'h0);
    tick();
    snb0_cdvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      snb0_cddata = 128'(32'hA0 + b); snb1_cddata = 128'(32'hB0 + b); #1;
      check("t2_s0_cdvalid", 128'(cdvalid), 128'(1'b1));
      check("t2_s0_cddata", cddata, 128'(32'hA0 + b));
      check("t2_s0_cdgnt", 128'(cd_gnt), 128'(2'b01));
      check("t2_s0_cdlast", 128'(cdlast), 128'(b == 3));
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      snb0_cddata = 128'(32'hA8 + b); snb1_cddata = 128'(32'hB8 + b); #1;
      check("t2_s1_cddata", cddata, 128'(32'hB8 + b));
      check("t2_s1_cdgnt", 128'(cd_gnt), 128'(2'b10));
      check("t2_s1_cdlast", 128'(cdlast), 128'(b == 3));
      tick();
    end
    snb0_cdvalid = 1'b0; snb1_cdvalid = 1'b0; #1;
    check("t2_end_cdvalid", 128'(cdvalid), 128'(1'b0));
    check("t2_end_idle", 128'(idle), 128'(1'b1));

    // 3: fill order FIFO, data CR blocked while ctcq still passes
    snb0_crvalid = 1'b1; snb1_crvalid = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_fill_gnt", 128'(cr_gnt), (i % 2 == 0) ? 128'(3'b001) : 128'(3'b010));
      tick(); #1;
    end
    check("t3_full", 128'(sel_full), 128'(1'b1));
    snb1_crvalid = 1'b0; ctcq_crvalid = 1'b1; ctcq_crresp = 5'h00; #1;
    check("t3_ctcq_gnt", 128'(cr_gnt), 128'(3'b100));
    tick();
    ctcq_crvalid = 1'b0; #1;
    check("t3_blocked_gnt", 128'(cr_gnt), 128'(3'b000));
    snb0_cdvalid = 1'b1; cd_grant = 1'b1;
    for (int b = 0; b < 4; b++) begin
      snb0_cddata = 128'(32'hD0 + b); #1;
      check("t3_cd_gnt", 128'(cd_gnt), 128'(2'b01));
      check("t3_cd_last", 128'(cdlast), 128'(b == 3));
      check("t3_pop_cycle_cr_gnt", 128'(cr_gnt), 128'(3'b000));
      tick();
    end
    snb0_cdvalid = 1'b0; #1;
    check("t3_after_pop_full", 128'(sel_full), 128'(1'b0));
    check("t3_after_pop_gnt", 128'(cr_gnt), 128'(3'b001));
    tick();
    snb0_crvalid = 1'b0; #1;
    check("t3_refull", 128'(sel_full), 128'(1'b1));
    check("t3_crresp", 128'(crresp), 128'(5'h01));

    // 4: EBIU stalls CR for 5 cycles with requests pending
    cr_grant = 1'b0;
    snb1_crvalid = 1'b1; snb1_crresp = 5'h0C;
    ctcq_crvalid = 1'b1; ctcq_crresp = 5'h0A; #1;
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_gnt", 128'(cr_gnt), 128'(3'b000));
      check("t4_stall_crvalid", 128'(crvalid), 128'(1'b1));
      check("t4_stall_crresp", 128'(crresp), 128'(5'h01));
      tick(); #1;
    end
    cr_grant = 1'b1; #1;
    check("t4_release_gnt", 128'(cr_gnt), 128'(3'b010));
    tick();
    snb1_crvalid = 1'b0; #1;
    check("t4_crresp_snb1", 128'(crresp), 128'(5'h0C));
    check("t4_gnt_ctcq", 128'(cr_gnt), 128'(3'b100));
    tick();
    ctcq_crvalid = 1'b0; #1;
    check("t4_crresp_ctcq", 128'(crresp), 128'(5'h0A));
    tick(); #1;
    check("t4_drain_crvalid", 128'(crvalid), 128'(1'b0));

    // 5: snb1 burst with cd_grant toggling 1,0,1,0...
    snb1_cdvalid = 1'b1;
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      cd_grant = (k % 2 == 0);
      snb1_cddata = 128'(32'hC0 + k); #1;
      check("t5_cdvalid", 128'(cdvalid), 128'(1'b1));
      check("t5_cddata", cddata, 128'(32'hC0 + k));
      check("t5_cdgnt", 128'(cd_gnt), {126'b0, cd_grant, 1'b0});
      check("t5_cdlast", 128'(cdlast), 128'(acc == 3));
      if (cd_grant) acc++;
      tick();
    end
    snb1_cdvalid = 1'b0; cd_grant = 1'b1; #1;
    check("t5_single_pop", 128'(sel_full), 128'(1'b0));
    check("t5_cdvalid_off", 128'(cdvalid), 128'(1'b0));

    // 6: reset mid-burst with three entries queued and a CR held
    cr_grant = 1'b0;
    snb0_crvalid = 1'b1; snb0_crresp = 5'h00; #1;
    check("t6_pre_gnt", 128'(cr_gnt), 128'(3'b001));
    tick();
    snb0_crvalid = 1'b0;
    snb0_cdvalid = 1'b1; cd_grant = 1'b1;
    for (int b = 0; b < 2; b++) begin
      snb0_cddata = 128'(32'hE0 + b); #1;
      check("t6_pre_cdgnt", 128'(cd_gnt), 128'(2'b01));
      check("t6_pre_cdlast", 128'(cdlast), 128'(1'b0));
      tick();
    end
    cpurst = 1'b1; snb0_cdvalid = 1'b0; cd_grant = 1'b0; #1;
    tick();
    cpurst = 1'b0; #1;
    check("t6_crvalid", 128'(crvalid), 128'(1'b0));
    check("t6_crresp", 128'(crresp), 128'(5'h00));
    check("t6_cdvalid", 128'(cdvalid), 128'(1'b0));
    check("t6_full", 128'(sel_full), 128'(1'b0));
    check("t6_idle", 128'(idle), 128'(1'b1));
    snb0_cdvalid = 1'b1; cd_grant = 1'b1; #1;
    check("t6_empty_cdvalid", 128'(cdvalid), 128'(1'b0));
    check("t6_empty_cdgnt", 128'(cd_gnt), 128'(2'b00));
    cr_grant = 1'b1;
    snb0_crvalid = 1'b1; snb0_crresp = 5'h01;
    snb1_crvalid = 1'b1; snb1_crresp = 5'h00; #1;
    check("t6_rr_restart", 128'(cr_gnt), 128'(3'b001));
    tick();
    snb0_crvalid = 1'b0; snb1_crvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      snb0_cddata = 128'(32'hF0 + b); #1;
      check("t6_cdgnt", 128'(cd_gnt), 128'(2'b01));
      check("t6_cdlast", 128'(cdlast), 128'(b == 3));
      tick();
    end
    snb0_cdvalid = 1'b0; #1;
    check("t6_end_cdvalid", 128'(cdvalid), 128'(1'b0));
    check("t6_end_idle", 128'(idle), 128'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_ciu_ebiuif_crcd_ctrl.md
Name: ct_ciu_ebiuif_crcd_ctrl

Overview:
Snoop-response scheduler between the snoop sources (snb0, snb1, ctcq) and the EBIU CR/CD channels.
- Round-robin arbitrates the three CR (snoop response) requesters onto one registered CR output.
- Records the order of data-carrying responses and sequences the matching 4-beat CD transfers from snb0/snb1 in that order.
- Drives the "CR select full" back-pressure used by the EBIU interface to stall new AC snoops.

Parameters:
CD_DEPTH, 4, entries in the CD order FIFO (outstanding data-carrying responses awaiting CD).
CD_BEATS, 4, 128-bit beats per CD transfer (64B line).

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset; synchronous, active-high
snb0_ebiuif_crvalid  in  1  snb0 CR request
snb0_ebiuif_crresp  in  5  snb0 CR response; bit0 = DataTransfer
ebiuif_snb0_cr_grant  out  1  snb0 CR accepted this cycle
snb0_ebiuif_cdvalid  in  1  snb0 CD beat valid
snb0_ebiuif_cddata  in  128  snb0 CD beat data
ebiuif_snb0_cd_grant  out  1  snb0 CD beat accepted
snb1_ebiuif_crvalid / snb1_ebiuif_crresp[4:0] / ebiuif_snb1_cr_grant  in/in/out  1/5/1  as snb0
snb1_ebiuif_cdvalid / snb1_ebiuif_cddata[127:0] / ebiuif_snb1_cd_grant  in/in/out  1/128/1  as snb0
ctcq_ebiuif_crvalid  in  1  ctcq (DVM) CR request; never carries data
ctcq_ebiuif_crresp  in  5  ctcq CR response
ebiuif_ctcq_cr_grant  out  1  ctcq CR accepted
ebiuif_ebiu_crvalid  out  1  CR output valid (registered)
ebiuif_ebiu_crresp  out  5  CR output response (registered)
ebiu_ebiuif_cr_grant  in  1  EBIU accepts CR this cycle
ebiuif_ebiu_cdvalid  out  1  CD output valid
ebiuif_ebiu_cddata  out  128  CD output data
ebiuif_ebiu_cdlast  out  1  last CD beat
ebiu_ebiuif_cd_grant  in  1  EBIU accepts CD beat
ebiuif_cr_sel_full  out  1  CD order FIFO full
ebiuif_crcd_idle  out  1  no CR pending and order FIFO empty

Behaviour:
Reset (cpurst=1 at clock edge, from any state including mid-burst):
- crvalid, crresp, all grants, cdvalid, cdlast = 0; cddata = 0.
- Order FIFO emptied; beat counter = 0.
- RR pointer = snb0 highest priority.
- cr_sel_full = 0; crcd_idle = 1.

CR path:
- cr_load = !crvalid_q | ebiu_ebiuif_cr_grant.
- Eligible requesters:
  - snbX is eligible if crvalid=1 and (crresp[0]=0 or order FIFO not full).
  - ctcq is eligible if crvalid=1; ctcq crresp is forwarded unmodified.
- Round-robin over {snb0, snb1, ctcq}: priority starts after the last granted requester; the pointer updates only on a grant.
- On cr_load with ≥1 eligible requester:
  - grant that requester (1 cycle, combinational);
  - capture its crresp;
  - crvalid_q = 1 on the next cycle.
- Request→crvalid latency is 1 cycle. Back-to-back throughput is 1/cycle while cr_grant is held high.
- On cr_load with no eligible requester: crvalid_q = 0.
- crvalid/crresp hold stable while crvalid=1 and cr_grant=0.

Order FIFO:
- Push the source id (0=snb0, 1=snb1) when an snbX grant has crresp[0]=1.
- Full = count==CD_DEPTH. Full blocks data-carrying snb CRs even if a pop occurs the same cycle.
- Simultaneous push+pop when not full: count unchanged.
- Pointers wrap modulo CD_DEPTH.
- cr_sel_full = full (combinational from count).

CD path:
- Active only when the FIFO is non-empty. Source = head id.
- ebiuif_ebiu_cdvalid = head_valid & src_cdvalid; cddata = src_cddata (combinational pass-through, 0 when not valid).
- ebiuif_snbX_cd_grant = ebiu_ebiuif_cd_grant & cdvalid & (head==X).
- The non-head source's cdvalid is ignored; it receives no grant.
- Beat counter (2 bits) increments per accepted beat; cdlast = (cnt==CD_BEATS-1) & cdvalid.
- On an accepted last beat: counter → 0, FIFO pop.
- CD may complete before its CR is accepted by EBIU; no ordering between the CR and CD channels is enforced beyond the push at CR-grant time.

crcd_idle = !crvalid_q & FIFO empty & no crvalid input.

Test Plan:
1. All three CR requesters valid constantly, cr_grant=1, crresp=5'h00 → grant order snb0, snb1, ctcq, snb0…; crvalid first high 1 cycle after the first request.
2. snb0 CR crresp=5'h01 then snb1 CR 5'h01; snb1 then snb0 CD data beats offered → CD output takes 4 snb0 beats (cdlast on beat 4) then 4 snb1 beats; snb1 receives no cd_grant before the snb0 pop.
3. Four data CRs granted, no CD traffic → cr_sel_full=1; a fifth snb0 data CR is not granted while ctcq CR 5'h00 is granted; after one CD burst completes, snb0 is granted next cycle.
4. crvalid_q=1, cr_grant=0 for 5 cycles with new requests pending → crresp stable, no requester grants; cr_grant=1 → next CR loads the same cycle.
5. cd_grant toggled 1,0,1,0… during a burst → cdlast only on the 4th accepted beat; pop count=1.
6. cpurst asserted mid-CD-burst (beat 2) with FIFO count=3 → next cycle count=0, cdvalid=0, crvalid=0, crcd_idle=1 (given no inputs), RR restarts at snb0.
